// File: rtl/iw_alu_pipe.sv
// iw_alu_pipe: buffered ALU stage between instruction decode and writeback.
//
// Instruction words are pushed into a DEPTH-entry FIFO over a valid/ready
// handshake. One word per cycle is popped and executed. Its result, flags and
// address are held in a result register behind a second valid/ready handshake.
//
// Parameters:
//   DATA_W  operand/result width (>= 8)
//   ADDR_W  width of the carried-through address field
//   DEPTH   FIFO depth (power of 2, >= 2)
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   iw_valid/iw_ready/iw  input handshake; iw = {a, b, opcode[7:0], address}
//   res_valid/res_ready   output handshake
//   res_data              ALU result
//   res_address           address carried through from the input word
//   res_flags             {illegal, overflow, carry, zero}
//   level                 FIFO occupancy
//   illegal_cnt           saturating count of executed illegal opcodes
//
// Configuration macro: IW_ALU_MUL_EN -- when defined, opcode 8'h08 is an
// unsigned multiply (low DATA_W bits). Otherwise opcode 8'h08 is illegal.

module iw_alu_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 24,
    parameter int DEPTH  = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           iw_valid,
    output logic                           iw_ready,
    input  logic [2*DATA_W+8+ADDR_W-1:0]   iw,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [DATA_W-1:0]              res_data,
    output logic [ADDR_W-1:0]              res_address,
    output logic [3:0]                     res_flags,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic [15:0]                    illegal_cnt
);

    localparam int IW_W  = 2*DATA_W + 8 + ADDR_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);
    localparam int SH_W  = $clog2(DATA_W);

    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic [IW_W-1:0]   fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [ADDR_W-1:0] res_addr_q, res_addr_d;
    logic [3:0]        res_flags_q, res_flags_d;
    logic [15:0]       ill_cnt_q, ill_cnt_d;

    logic push, pop;

    // Ready depends only on registered occupancy, so a push is refused when
    // full even if a pop happens in the same cycle.
    assign iw_ready = (level_q != LVL_W'(DEPTH));
    assign push     = iw_valid && iw_ready;
    assign pop      = (level_q != '0) && (!res_valid_q || res_ready);

    // FIFO storage carries data only; pointers/level alone define contents.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr_q] <= iw;
    end

    // Head word decode and combinational ALU.
    logic [IW_W-1:0]   head;
    logic [DATA_W-1:0] op_a, op_b, alu_data;
    logic [7:0]        opcode;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W:0]   sum_ext, diff_ext;
    logic              alu_carry, alu_ovf, alu_ill;
    logic [3:0]        alu_flags;

    always_comb begin
        head      = fifo_mem[rd_ptr_q];
        op_a      = head[IW_W-1 -: DATA_W];
        op_b      = head[IW_W-1-DATA_W -: DATA_W];
        opcode    = head[ADDR_W +: 8];
        op_addr   = head[ADDR_W-1:0];
        sum_ext   = {1'b0, op_a} + {1'b0, op_b};
        diff_ext  = {1'b0, op_a} - {1'b0, op_b};
        alu_data  = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_ill   = 1'b0;
        case (opcode)
            8'h00: begin
                alu_data  = sum_ext[DATA_W-1:0];
                alu_carry = sum_ext[DATA_W];
                // Same-sign operands producing a result of the other sign.
                alu_ovf   = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                            (sum_ext[DATA_W-1] != op_a[DATA_W-1]);
            end
            8'h01: begin
                alu_data  = diff_ext[DATA_W-1:0];
                alu_carry = diff_ext[DATA_W];  // borrow out
                alu_ovf   = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                            (diff_ext[DATA_W-1] != op_a[DATA_W-1]);
            end
            8'h02: alu_data = op_a & op_b;
            8'h03: alu_data = op_a | op_b;
            8'h04: alu_data = op_a ^ op_b;
            8'h05: alu_data = op_a << op_b[SH_W-1:0];
            8'h06: alu_data = op_a >> op_b[SH_W-1:0];
            8'h07: alu_data = op_a;
`ifdef IW_ALU_MUL_EN
            8'h08: alu_data = op_a * op_b;
`endif
            default: alu_ill = 1'b1;
        endcase
        alu_flags = alu_ill ? 4'b1000 : {1'b0, alu_ovf, alu_carry, (alu_data == '0)};
    end

    // Next-state for control and the result register.
    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d     = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_addr_d  = res_addr_q;
        res_flags_d = res_flags_q;
        ill_cnt_d   = ill_cnt_q;
        if (pop) begin
            res_valid_d = 1'b1;
            res_data_d  = alu_data;
            res_addr_d  = op_addr;
            res_flags_d = alu_flags;
            if (alu_ill) ill_cnt_d = sat_inc16(ill_cnt_q);
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_addr_q  <= '0;
            res_flags_q <= '0;
            ill_cnt_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_addr_q  <= res_addr_d;
            res_flags_q <= res_flags_d;
            ill_cnt_q   <= ill_cnt_d;
        end
    end

    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_address = res_addr_q;
    assign res_flags   = res_flags_q;
    assign level       = level_q;
    assign illegal_cnt = ill_cnt_q;

endmodule

// File: doc/iw_alu_pipe.md
# iw_alu_pipe

Parametrised, buffered successor to the single-instruction ALU front end: accepts packed instruction words (operands A/B, opcode, address) over a valid/ready handshake, queues them in an internal FIFO, executes one per cycle and presents a registered result with flags over a second valid/ready handshake. It sits between the instruction fetch/decode stage and the writeback stage, which is addressed by the carried-through `address` field.

## Interface
- `DATA_W`, 32: operand and result width; must be at least 8.
- `ADDR_W`, 24: width of the address field.
- `DEPTH`, 4: input FIFO depth; must be a power of 2 and at least 2.
- `clock`  in  1  single clock; all logic uses the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `iw_valid`  in  1  an input instruction word is offered.
- `iw_ready`  out  1  the FIFO can accept a word.
- `iw`  in  2*DATA_W+8+ADDR_W  packed instruction word. Fields MSB→LSB: `a[DATA_W]`, `b[DATA_W]`, `opcode[8]`, `address[ADDR_W]`.
- `res_valid`  out  1  result register holds a valid result.
- `res_ready`  in  1  downstream accepts the result.
- `res_data`  out  DATA_W  ALU result.
- `res_address`  out  ADDR_W  address field carried through from the input word.
- `res_flags`  out  4  {illegal, overflow, carry, zero}.
- `level`  out  $clog2(DEPTH+1)  current FIFO occupancy.
- `illegal_cnt`  out  16  count of illegal opcodes executed; saturating.

## Operation
- **Push:** when `iw_valid && iw_ready`. `iw_ready = (level != DEPTH)`. A push is refused when the FIFO is full, even if a pop occurs in the same cycle.
- **Pop/execute:** when FIFO is non-empty and `(!res_valid || res_ready)`. On pop:
  - the combinational ALU result of the head word loads the result register;
  - `res_valid` is set.
- **res_valid clear:** when `res_ready` is high and no pop occurs.
- **Hold:** `res_*` outputs are stable while `res_valid && !res_ready`.
- **Simultaneous push and pop:** `level` is unchanged.
- **Pointers:** `log2(DEPTH)`-bit read/write pointers wrap modulo DEPTH.
- **Opcodes** (arithmetic is modulo 2^DATA_W):
  - 00 ADD: carry = carry-out; overflow = signed overflow.
  - 01 SUB a−b: carry = borrow; overflow = signed overflow.
  - 02 AND, 03 OR, 04 XOR.
  - 05 SHL a by `b[$clog2(DATA_W)-1:0]`; 06 SHR, logical, same shift amount.
  - 07 PASS_A.
  - 08 MUL: low DATA_W bits of a*b, unsigned; available only when the configuration macro is defined.
- **Flags:**
  - carry and overflow are 0 for opcodes other than ADD and SUB.
  - zero = (result == 0) for all legal opcodes.
- **Illegal opcode:** result 0, flags = 4'b1000 (zero forced 0). `illegal_cnt` increments on pop and saturates at 16'hFFFF.
- **Reset:** clears pointers and discards FIFO contents and any pending result, including mid-transfer. After reset:
  - `level` = 0, `iw_ready` = 1, `res_valid` = 0;
  - `res_data` = 0, `res_address` = 0, `res_flags` = 0;
  - `illegal_cnt` = 0.

## Timing
- **Latency:** a word pushed at edge k, with the FIFO empty and the result register free, gives `res_valid` high after edge k+1.
- **Throughput:** one result per cycle with `res_ready` held high.
- **Outputs:** `iw_ready` and `level` are derived from registered state only; there is no combinational path from `res_ready`.
- **Backpressure:** with `res_ready` low, the FIFO fills. `iw_ready` drops the cycle after `level` reaches DEPTH.
- **Reset during handshake:** a push offered in the cycle `reset` is high is ignored.

## Configuration
- `IW_ALU_MUL_EN` defined: opcode 08 executes an unsigned multiply, low half only; carry and overflow are 0.
- `IW_ALU_MUL_EN` undefined: no multiplier is synthesised; opcode 08 is treated as illegal.

## Test plan
- **Reset values:** assert `reset` 2 cycles while `iw_valid` = 1 → `level` = 0, `res_valid` = 0, `illegal_cnt` = 0, no word captured.
- **Arithmetic, DATA_W=32:** ADD a=32'hFFFF_FFFF, b=1 → `res_data` 0, flags 4'b0011. SUB a=32'h8000_0000, b=1 → 32'h7FFF_FFFF, flags 4'b0100. `res_address` equals input address; result appears one cycle after push.
- **Backpressure:**
  - hold `res_ready`=0 and push 6 words with DEPTH=4 → 5 accepted (4 in the FIFO, 1 in the result register); `iw_ready`=0.
  - release `res_ready` → results emerge in order, one per cycle, with none lost or duplicated.
- **Wrap-around:** stream 20 words with random `res_ready` → output order and values match a reference model across pointer wrap.
- **Illegal opcodes:** opcode 8'hFF ×3 → result 0, flags 4'b1000, `illegal_cnt` = 3. Opcode 08 → illegal when `IW_ALU_MUL_EN` is undefined; 7×6=42 when defined.
- **Reset mid-operation:** pulse `reset` with 3 words queued and `res_valid`=1 → everything cleared next cycle; a subsequent push executes normally.
